stream_bit_reverser: RTL and testbench

//  Parametrised, streaming successor to the combinational 8-bit flip function.
//  Per-beat selectable reordering (pass, bit reverse, group reverse, half swap) of a WIDTH-bit word.

---
 rtl/stream_bit_reverser.sv | 66 ++++++
 tb/tb_stream_bit_reverser.sv | 111 +++++++++++
 2 files changed

// File: rtl/stream_bit_reverser.sv
// stream_bit_reverser: per-beat pass/bit-rev/group-rev/half-swap of in_data into a DEPTH-entry FIFO; valid/ready on both sides, beat_count counts pops, level is occupancy
module stream_bit_reverser #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [CNT_W-1:0]         beat_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NG = WIDTH / GROUP;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [LW-1:0]    cnt;
  logic [CNT_W-1:0] beats;
  logic [WIDTH-1:0] last, rev, grp, xf;
  logic             rst_q, push, pop;
  assign in_ready   = !reset && !rst_q && cnt != LW'(DEPTH);
  assign out_valid  = !reset && cnt != '0;
  assign out_data   = reset ? '0 : cnt != '0 ? mem[rp] : last;
  assign level      = reset ? '0 : cnt;
  assign beat_count = reset ? '0 : beats;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  always_comb begin
    rev = '0;
    grp = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = in_data[WIDTH-1-i];
    for (int k = 0; k < NG; k++) grp[k*GROUP +: GROUP] = in_data[(NG-1-k)*GROUP +: GROUP];
    xf = in_mode == 2'b00 ? in_data :
         in_mode == 2'b01 ? rev :
         in_mode == 2'b10 ? grp : {in_data[WIDTH/2-1:0], in_data[WIDTH-1:WIDTH/2]};
  end
  always_ff @(posedge clk)
    if (push && !reset) mem[wp] <= xf;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      beats <= '0;
      last  <= '0;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      cnt   <= cnt + LW'(push) - LW'(pop);
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp    <= rp + 1'b1;
        last  <= mem[rp];
        beats <= beats + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_bit_reverser.sv
// tb_stream_bit_reverser: randomized and directed checks against a queue-based reference model
module tb_stream_bit_reverser;
  logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [1:0]  in_mode = 0;
  logic [15:0] in_data = 0;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [7:0]  beat_count;
  logic [2:0]  level;
  int          n_cmp = 0, n_err = 0;
  logic [15:0] q [$];
  int          m_beats = 0;
  logic [15:0] m_last = 0;
  logic        m_rstq = 1;
  int          b0;
  stream_bit_reverser #(.WIDTH(16), .GROUP(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_count(beat_count), .level(level)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] ref_xf(input logic [15:0] x, input logic [1:0] m);
    int r = 0;
    case (m)
      2'd0: r = int'(x);
      2'd1: for (int i = 0; i < 16; i++) r = (r << 1) | ((int'(x) >> i) & 1);
      2'd2: for (int k = 0; k < 4; k++) r = (r << 4) | ((int'(x) >> (4 * k)) & 15);
      default: r = ((int'(x) << 8) | (int'(x) >> 8)) & 32'hffff;
    endcase
    return r[15:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic r, input logic iv, input logic [1:0] m, input logic [15:0] d, input logic ordy);
    logic er, ev;
    logic [15:0] ed;
    @(negedge clk);
    reset = r; in_valid = iv; in_mode = m; in_data = d; out_ready = ordy;
    #1;
    er = !r && !m_rstq && q.size() < 4;
    ev = !r && q.size() > 0;
    ed = r ? 16'h0 : (q.size() > 0 ? q[0] : m_last);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("level", 32'(level), r ? 32'd0 : 32'(q.size()));
    chk("beat_count", 32'(beat_count), r ? 32'd0 : 32'(m_beats));
    @(posedge clk);
    if (r) begin
      q.delete(); m_beats = 0; m_last = 0; m_rstq = 1;
    end else begin
      if (ev && ordy) begin
        m_last = q.pop_front();
        m_beats = (m_beats + 1) % 256;
      end
      if (iv && er) q.push_back(ref_xf(d, m));
      m_rstq = 0;
    end
  endtask
  initial begin
    logic [15:0] e2 [4];
    e2[0] = 16'h0001; e2[1] = 16'h8000; e2[2] = 16'h1000; e2[3] = 16'h0100;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int m = 0; m < 4; m++) begin
      cyc(0, 1, 2'(m), 16'h0001, 1);
      #1 chk("t2_dir", 32'(out_data), 32'(e2[m]));
    end
    cyc(0, 1, 2'b10, 16'h1234, 1);
    #1 chk("t3_grp", 32'(out_data), 32'h4321);
    cyc(0, 1, 2'b11, 16'h1234, 1);
    #1 chk("t3_half", 32'(out_data), 32'h3412);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 2'($urandom), 16'($urandom), 0);
    #1 chk("t4_full_lvl", 32'(level), 32'd4);
    chk("t4_full_rdy", 32'(in_ready), 32'd0);
    cyc(0, 0, 0, 0, 1);
    #1 chk("t4_pop_lvl", 32'(level), 32'd3);
    chk("t4_pop_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 2'($urandom), 16'($urandom), 0);
    cyc(0, 1, 2'($urandom), 16'($urandom), 0);
    b0 = m_beats;
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'($urandom), 16'($urandom), 1);
    #1 chk("t5_lvl", 32'(level), 32'd2);
    chk("t5_beats", 32'(beat_count), 32'((b0 + 10) % 256));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 2'($urandom), 16'($urandom), 0);
    for (int i = 0; i < 257; i++) cyc(0, 1, 2'($urandom), 16'($urandom), 1);
    #1 chk("t6_wrap", 32'(beat_count), 32'd1);
    cyc(0, 1, 2'($urandom), 16'($urandom), 0);
    cyc(0, 1, 2'($urandom), 16'($urandom), 0);
    #1 chk("t6_lvl3", 32'(level), 32'd3);
    cyc(1, 1, 2'($urandom), 16'($urandom), 1);
    #1 chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_lvl", 32'(level), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 97) == 0, 1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
